simon_game_core: RTL and testbench

- Parametrised single-FSM Simon Says engine. It generalises the fixed four-colour, 32-bit-sequence IDLE/DISPLAY/WAIT/CHECK chain into one block.
- Parameters: colour count, maximum sequence length, display timing and input timeout. Adds a practice (retry) mode.
- Owns LFSR sequence generation, sequence storage, lamp playback, button capture and checking.
- Sits between the pad-level input decode and the lamp/status output registers in the top level.

---
 rtl/simon_game_core.sv | 202 ++++++++++++++++++++
 tb/tb_simon_game_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_game_core.sv
// Simon Says engine: LFSR sequence generation, storage, timed lamp playback and press checking.
// Lamp and status are registered and change one clock after the FSM decides; there is no backpressure.
module simon_game_core #(
  parameter int NUM_COLOURS    = 4,
  parameter int MAX_LEN        = 16,
  parameter int HOLD_CYCLES    = 1000000,
  parameter int GAP_CYCLES     = 250000,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int PRACTICE       = 0,
  localparam int COL_W = $clog2(NUM_COLOURS),
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             seed,
  input  logic [NUM_COLOURS-1:0] btn,
  output logic [NUM_COLOURS-1:0] lamp,
  output logic [2:0]             state_dbg,
  output logic [LEN_W-1:0]       round,
  output logic                   win,
  output logic                   lose,
  output logic                   busy
);

  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int T_MAX1 = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int T_MAX  = (T_MAX1 > TIMEOUT_CYCLES) ? T_MAX1 : TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] ROUND_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             lfsr, lfsr_nxt, lfsr_step;
  logic [LEN_W-1:0]       round_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt, idx_last;
  logic [TMR_W-1:0]       tmr, tmr_nxt;
  logic                   pend, pend_nxt;
  logic [NUM_COLOURS-1:0] lamp_nxt, prev_btn, exp_oh;
  logic                   prev_start, start_evt, press, miss, mem_we;
  logic [COL_W-1:0]       new_col, show_col;
  logic [COL_W-1:0]       mem [MAX_LEN];

  function automatic logic [NUM_COLOURS-1:0] onehot(input logic [COL_W-1:0] c);
    logic [NUM_COLOURS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign new_col   = lfsr_step[COL_W-1:0];
  assign start_evt = start & ~prev_start;
  assign press     = (btn != '0) && (prev_btn == '0);
  assign idx_last  = IDX_W'(round - LEN_W'(1));
  assign exp_oh    = onehot(mem[idx]);

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    round_nxt = round;
    idx_nxt   = idx;
    tmr_nxt   = tmr;
    pend_nxt  = pend;
    mem_we    = 1'b0;
    miss      = 1'b0;
    lamp_nxt  = '0;
    show_col  = '0;

    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_evt) begin
          state_nxt = S_GEN;
          lfsr_nxt  = (seed == 8'h00) ? 8'h01 : seed;
          round_nxt = '0;
        end
      end
      S_GEN: begin
        lfsr_nxt  = lfsr_step;
        mem_we    = (round != ROUND_MAX);
        round_nxt = (round != ROUND_MAX) ? round + 1'b1 : round;
        idx_nxt   = '0;
        tmr_nxt   = '0;
        state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tmr == HOLD_LAST) begin
          tmr_nxt   = '0;
          state_nxt = S_SHOW_OFF;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_SHOW_OFF: begin
        if (tmr == GAP_LAST) begin
          tmr_nxt = '0;
          if (idx == idx_last) begin
            idx_nxt   = '0;
            state_nxt = S_INPUT;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_SHOW_ON;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_INPUT: begin
        // round complete: hold here, timer frozen, until the last button is released
        if (pend) begin
          if (btn == '0) begin
            pend_nxt  = 1'b0;
            state_nxt = S_GEN;
          end
        end else if (press) begin
          tmr_nxt = '0;
          if (btn == exp_oh) begin
            if (idx == idx_last) begin
              if (round == ROUND_MAX) state_nxt = S_WIN;
              else                    pend_nxt  = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            miss = 1'b1;
          end
        end else if (tmr == TO_LAST) begin
          miss = 1'b1;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end

        if (miss) begin
          if (PRACTICE != 0) begin
            idx_nxt   = '0;
            tmr_nxt   = '0;
            state_nxt = S_SHOW_ON;
          end else begin
            state_nxt = S_LOSE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // bypass the colour being written this cycle so the first lamp of a round is not stale
    show_col = (mem_we && idx_nxt == round[IDX_W-1:0]) ? new_col : mem[idx_nxt];
    case (state_nxt)
      S_SHOW_ON: lamp_nxt = onehot(show_col);
      S_INPUT:   lamp_nxt = btn;
      S_WIN:     lamp_nxt = {NUM_COLOURS{1'b1}};
      default:   lamp_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lamp       <= '0;
      round      <= '0;
      lfsr       <= 8'h01;
      idx        <= '0;
      tmr        <= '0;
      pend       <= 1'b0;
      prev_btn   <= '0;
      prev_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      lamp       <= lamp_nxt;
      round      <= round_nxt;
      lfsr       <= lfsr_nxt;
      idx        <= idx_nxt;
      tmr        <= tmr_nxt;
      pend       <= pend_nxt;
      prev_btn   <= btn;
      prev_start <= start;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[round[IDX_W-1:0]] <= new_col;
  end

  assign state_dbg = state;
  assign win       = (state == S_WIN);
  assign lose      = (state == S_LOSE);
  assign busy      = (state != S_IDLE) && (state != S_WIN) && (state != S_LOSE);

endmodule

// File: tb/tb_simon_game_core.sv
// Scoreboard bench: strict and practice instances; every output change is checked with its predecessor's dwell.
module tb_simon_game_core;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 20;
  localparam int K_OK = 0, K_FINAL = 1, K_WIN = 2, K_LOSE = 3, K_MISS = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] lamp;
    logic [1:0] round;
    logic       win;
    logic       lose;
    logic       busy;
  } snap_t;

  typedef struct packed {
    snap_t       s;
    logic [15:0] dw;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_p, start_s, start_p;
  logic [7:0] seed_s, seed_p;
  logic [3:0] btn_s, btn_p, lamp_s, lamp_p;
  logic [2:0] st_s, st_p;
  logic [1:0] round_s, round_p;
  logic       win_s, win_p, lose_s, lose_p, busy_s, busy_p;

  simon_game_core #(.NUM_COLOURS(4), .MAX_LEN(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                    .TIMEOUT_CYCLES(TMO), .PRACTICE(0)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .seed(seed_s), .btn(btn_s), .lamp(lamp_s),
    .state_dbg(st_s), .round(round_s), .win(win_s), .lose(lose_s), .busy(busy_s));

  simon_game_core #(.NUM_COLOURS(4), .MAX_LEN(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                    .TIMEOUT_CYCLES(TMO), .PRACTICE(1)) dut_p (
    .clk(clk), .rst(rst_p), .start(start_p), .seed(seed_p), .btn(btn_p), .lamp(lamp_p),
    .state_dbg(st_p), .round(round_p), .win(win_p), .lose(lose_p), .busy(busy_p));

  exp_t       q0[$];
  exp_t       q1[$];
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] seq [3]  = '{2'd2, 2'd0, 2'd0};

  task automatic push(input int d, input logic [2:0] st, input logic [3:0] lamp, input int r, input int dw);
    exp_t e;
    e.s.st    = st;
    e.s.lamp  = lamp;
    e.s.round = 2'(r);
    e.s.win   = (st == 3'd5);
    e.s.lose  = (st == 3'd6);
    e.s.busy  = !(st == 3'd0 || st == 3'd5 || st == 3'd6);
    e.dw      = 16'(dw);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_event(input int d, input snap_t act, input int dw);
    exp_t e;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut%0d got st=%0d lamp=%b round=%0d win=%b lose=%b busy=%b required no change",
               d, act.st, act.lamp, act.round, act.win, act.lose, act.busy);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if (act != e.s || (e.dw != 16'd0 && dw != int'(e.dw))) begin
        failures++;
        $display("FAIL event dut%0d t=%0t got st=%0d lamp=%b round=%0d win=%b lose=%b busy=%b after %0d cyc, required st=%0d lamp=%b round=%0d win=%b lose=%b busy=%b after %0d cyc",
                 d, $time, act.st, act.lamp, act.round, act.win, act.lose, act.busy, dw,
                 e.s.st, e.s.lamp, e.s.round, e.s.win, e.s.lose, e.s.busy, e.dw);
      end
    end
  endtask

  // monitor: any change of the observable outputs is one scoreboard event
  snap_t cur  [2];
  snap_t prev [2];
  int    dwc  [2] = '{0, 0};
  bit    seen [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cur[0] = {st_s, lamp_s, round_s, win_s, lose_s, busy_s};
    cur[1] = {st_p, lamp_p, round_p, win_p, lose_p, busy_p};
    for (int d = 0; d < 2; d++) begin
      if (!seen[d] || cur[d] != prev[d]) begin
        check_event(d, cur[d], dwc[d]);
        prev[d] = cur[d];
        dwc[d]  = 1;
        seen[d] = 1'b1;
      end else begin
        dwc[d]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int d, input logic [3:0] b);
    if (d == 0) btn_s = b;
    else        btn_p = b;
  endtask

  // leaves the caller at the drive slot of the GEN cycle
  task automatic start_game(input int d, input logic [7:0] sd);
    push(d, 3'd1, 4'h0, 0, 0);
    if (d == 0) begin start_s = 1'b1; seed_s = sd; end
    else        begin start_p = 1'b1; seed_p = sd; end
    step(1);
    if (d == 0) start_s = 1'b0;
    else        start_p = 1'b0;
  endtask

  task automatic playback(input int d, input int r, input int first_dw);
    for (int i = 0; i < r; i++) begin
      push(d, 3'd2, 4'b0001 << seq[i], r, (i == 0) ? first_dw : GAP);
      push(d, 3'd3, 4'h0, r, HOLD);
    end
    push(d, 3'd4, 4'h0, r, GAP);
  endtask

  task automatic gen_and_show(input int d, input int r);
    playback(d, r, 1);
    step(1 + (HOLD + GAP) * r);
  endtask

  task automatic press(input int d, input logic [3:0] b, input int hold, input int kind, input int r);
    case (kind)
      K_OK:    begin push(d, 3'd4, b, r, 1); push(d, 3'd4, 4'h0, r, hold); end
      K_FINAL: begin push(d, 3'd4, b, r, 1); push(d, 3'd1, 4'h0, r, hold); end
      K_WIN:   push(d, 3'd5, 4'hF, r, 1);
      K_LOSE:  push(d, 3'd6, 4'h0, r, 1);
      default: ;
    endcase
    set_btn(d, b);
    step(hold);
    set_btn(d, 4'h0);
    if (kind == K_OK || kind == K_FINAL) step(1);
  endtask

  initial begin
    rst_s = 1'b1; rst_p = 1'b1; start_s = 1'b0; start_p = 1'b0;
    seed_s = 8'h00; seed_p = 8'h00; btn_s = 4'h0; btn_p = 4'h0;
    push(0, 3'd0, 4'h0, 0, 0);
    push(1, 3'd0, 4'h0, 0, 0);
    step(1);
    rst_s = 1'b0; rst_p = 1'b0;
    step(2);

    // strict: full game to WIN, sequence 2,0,0
    start_game(0, 8'h01);
    gen_and_show(0, 1);
    press(0, 4'b0100, 3, K_FINAL, 1);
    gen_and_show(0, 2);
    press(0, 4'b0100, 1, K_OK, 2);
    press(0, 4'b0001, 1, K_FINAL, 2);
    gen_and_show(0, 3);
    press(0, 4'b0100, 1, K_OK, 3);
    press(0, 4'b0001, 1, K_OK, 3);
    press(0, 4'b0001, 1, K_WIN, 3);
    step(3);

    // strict: wrong colour, multi-hot, timeout
    start_game(0, 8'h01);
    gen_and_show(0, 1);
    press(0, 4'b0010, 1, K_LOSE, 1);
    step(3);
    start_game(0, 8'h01);
    gen_and_show(0, 1);
    press(0, 4'b0101, 1, K_LOSE, 1);
    step(3);
    start_game(0, 8'h01);
    gen_and_show(0, 1);
    push(0, 3'd6, 4'h0, 1, TMO);
    step(TMO + 3);

    // strict: reset mid-playback, then seed 0 plays like seed 1 and loses in round 3
    start_game(0, 8'h00);
    push(0, 3'd2, 4'b0100, 1, 1);
    step(2);
    rst_s = 1'b1;
    push(0, 3'd0, 4'h0, 0, 2);
    step(1);
    rst_s = 1'b0;
    step(2);
    start_game(0, 8'h00);
    gen_and_show(0, 1);
    press(0, 4'b0100, 2, K_FINAL, 1);
    gen_and_show(0, 2);
    press(0, 4'b0100, 1, K_OK, 2);
    press(0, 4'b0001, 1, K_FINAL, 2);
    gen_and_show(0, 3);
    press(0, 4'b0010, 1, K_LOSE, 3);
    step(3);

    // practice: start during playback is ignored, misses and timeout replay the round
    start_game(1, 8'h01);
    playback(1, 1, 1);
    step(2);
    start_p = 1'b1;
    step(1);
    start_p = 1'b0;
    step(4);
    press(1, 4'b0010, 1, K_MISS, 1);
    playback(1, 1, 1);
    step(HOLD + GAP);
    playback(1, 1, TMO);
    step(TMO + HOLD + GAP);
    press(1, 4'b0100, 2, K_FINAL, 1);
    gen_and_show(1, 2);
    press(1, 4'b0100, 1, K_OK, 2);
    press(1, 4'b0100, 1, K_MISS, 2);
    playback(1, 2, 1);
    step(2 * (HOLD + GAP));
    press(1, 4'b0100, 1, K_OK, 2);
    press(1, 4'b0001, 1, K_FINAL, 2);
    gen_and_show(1, 3);
    step(2);

    push(0, 3'd0, 4'h0, 0, 0);
    push(1, 3'd0, 4'h0, 0, 0);
    rst_s = 1'b1; rst_p = 1'b1;
    step(1);
    rst_s = 1'b0; rst_p = 1'b0;
    step(3);

    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL drain_strict got %0d events outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL drain_practice got %0d events outstanding, required 0", q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
